// File: rtl/prediction_resolver_pkg.sv
// Shared types and constants for the perceptron prediction resolver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prediction_resolver_pkg;

    // Width of the signed perceptron sum produced by the adder tree.
    localparam int Y_OUT_WIDTH = 16;

    // Training threshold: |y| at or below this marks a low-confidence prediction.
    localparam int PRED_THETA = 30;

    // Opaque branch tag width carried from prediction to resolution.
    localparam int PRED_TAG_W = 6;

    // One in-flight prediction awaiting its branch outcome.
    typedef struct packed {
        logic                  taken;
        logic                  lowconf;
        logic [PRED_TAG_W-1:0] tag;
    } pred_entry_t;

endpackage

// File: rtl/prediction_resolver_fifo.sv
// In-order register-based queue of in-flight predictions (module pred_fifo).
// Latency: push visible at head the cycle after the write edge; head is combinational from the read pointer.
// Backpressure: push ignored when full, pop ignored when empty, flush clears pointers and count with priority.
// Ports: push/din write, pop advance, flush clear, full/empty/count status, head oldest entry.
module pred_fifo
    import prediction_resolver_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter type entry_t = pred_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  entry_t                   din,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output entry_t                   head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // Gating uses registered full/empty only, so a same-cycle pop never frees a slot
    // for a push and a same-cycle push never makes an entry poppable.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Payload storage needs no reset: entries are only read once counted in.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/prediction_resolver.sv
// Registers sign/low-confidence predictions, tracks them in order, and emits training requests on resolution.
// Latency: 1 cycle from accepted sum to pred_*, 1 cycle from accepted outcome to upd_*.
// Backpressure: y_ready = !full, res_ready = !empty (registered); pred/upd outputs are never stalled.
// Ports: y_* sum input, pred_* prediction output, res_* outcome input, upd_* training request,
//        occupancy in-flight count, mispredict_cnt saturating mispredict total, flush sync clear.
module prediction_resolver
    import prediction_resolver_pkg::*;
#(
    parameter int Y_W   = Y_OUT_WIDTH,
    parameter int THETA = PRED_THETA,
    parameter int DEPTH = 8,
    parameter int TAG_W = PRED_TAG_W,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      y_valid,
    input  logic signed [Y_W-1:0]     y_in,
    input  logic [TAG_W-1:0]          y_tag,
    output logic                      y_ready,
    output logic                      pred_valid,
    output logic                      pred_taken,
    output logic                      pred_lowconf,
    output logic [TAG_W-1:0]          pred_tag,
    input  logic                      res_valid,
    input  logic                      res_taken,
    output logic                      res_ready,
    output logic                      upd_valid,
    output logic                      upd_train,
    output logic                      upd_mispredict,
    output logic                      upd_dir,
    output logic [TAG_W-1:0]          upd_tag,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic [CNT_W-1:0]          mispredict_cnt
);

    // Same layout as pred_entry_t, sized by this instance's TAG_W.
    typedef struct packed {
        logic             taken;
        logic             lowconf;
        logic [TAG_W-1:0] tag;
    } entry_t;

    localparam logic [Y_W:0] THETA_V = (Y_W+1)'(THETA);

    logic                 full;
    logic                 empty;
    logic                 accept;
    logic                 resolve;
    logic signed [Y_W:0]  y_ext;
    logic [Y_W:0]         abs_y;
    logic                 mispredict;
    entry_t               new_ent;
    entry_t               head;

    // One extra bit so negating the most negative sum cannot overflow.
    assign y_ext   = {y_in[Y_W-1], y_in};
    assign abs_y   = y_ext[Y_W] ? unsigned'(-y_ext) : unsigned'(y_ext);

    assign new_ent.taken   = ~y_in[Y_W-1];
    assign new_ent.lowconf = (abs_y <= THETA_V);
    assign new_ent.tag     = y_tag;

    assign y_ready    = !full;
    assign res_ready  = !empty;
    assign accept     = y_valid && !full;
    assign resolve    = res_valid && !empty;
    assign mispredict = head.taken ^ res_taken;

    pred_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (y_valid),
        .din   (new_ent),
        .pop   (res_valid),
        .full  (full),
        .empty (empty),
        .count (occupancy),
        .head  (head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid     <= 1'b0;
            pred_taken     <= 1'b0;
            pred_lowconf   <= 1'b0;
            pred_tag       <= '0;
            upd_valid      <= 1'b0;
            upd_train      <= 1'b0;
            upd_mispredict <= 1'b0;
            upd_dir        <= 1'b0;
            upd_tag        <= '0;
            mispredict_cnt <= '0;
        end else begin
            pred_valid <= accept && !flush;
            upd_valid  <= resolve && !flush;
            // Payload registers hold their last value when nothing is accepted.
            if (accept && !flush) begin
                pred_taken   <= new_ent.taken;
                pred_lowconf <= new_ent.lowconf;
                pred_tag     <= new_ent.tag;
            end
            if (resolve && !flush) begin
                upd_train      <= mispredict | head.lowconf;
                upd_mispredict <= mispredict;
                upd_dir        <= res_taken;
                upd_tag        <= head.tag;
                if (mispredict && (mispredict_cnt != '1)) begin
                    mispredict_cnt <= mispredict_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_prediction_resolver.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and randomized traffic
// checked against a queue-based reference model. A second instance with CNT_W=4 shares all inputs.
module tb_prediction_resolver;
    import prediction_resolver_pkg::*;

    localparam int Y_W = 16;
    localparam int TAG_W = 6;
    localparam int DEPTH = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 flush = 1'b0;
    logic                 y_valid = 1'b0;
    logic signed [Y_W-1:0] y_in = '0;
    logic [TAG_W-1:0]     y_tag = '0;
    logic                 res_valid = 1'b0;
    logic                 res_taken = 1'b0;

    logic y_ready, pred_valid, pred_taken, pred_lowconf, res_ready;
    logic upd_valid, upd_train, upd_mispredict, upd_dir;
    logic [TAG_W-1:0] pred_tag, upd_tag;
    logic [3:0]  occupancy;
    logic [15:0] mispredict_cnt;

    logic s_y_ready, s_pred_valid, s_pred_taken, s_pred_lowconf, s_res_ready;
    logic s_upd_valid, s_upd_train, s_upd_mispredict, s_upd_dir;
    logic [TAG_W-1:0] s_pred_tag, s_upd_tag;
    logic [3:0] s_occupancy;
    logic [3:0] s_cnt;

    always #5 clk = ~clk;

    prediction_resolver dut (
        .clk(clk), .rst(rst), .flush(flush),
        .y_valid(y_valid), .y_in(y_in), .y_tag(y_tag), .y_ready(y_ready),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_lowconf(pred_lowconf), .pred_tag(pred_tag),
        .res_valid(res_valid), .res_taken(res_taken), .res_ready(res_ready),
        .upd_valid(upd_valid), .upd_train(upd_train), .upd_mispredict(upd_mispredict),
        .upd_dir(upd_dir), .upd_tag(upd_tag),
        .occupancy(occupancy), .mispredict_cnt(mispredict_cnt)
    );

    prediction_resolver #(.CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .flush(flush),
        .y_valid(y_valid), .y_in(y_in), .y_tag(y_tag), .y_ready(s_y_ready),
        .pred_valid(s_pred_valid), .pred_taken(s_pred_taken), .pred_lowconf(s_pred_lowconf), .pred_tag(s_pred_tag),
        .res_valid(res_valid), .res_taken(res_taken), .res_ready(s_res_ready),
        .upd_valid(s_upd_valid), .upd_train(s_upd_train), .upd_mispredict(s_upd_mispredict),
        .upd_dir(s_upd_dir), .upd_tag(s_upd_tag),
        .occupancy(s_occupancy), .mispredict_cnt(s_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit       taken;
        bit       lowconf;
        bit [5:0] tag;
    } m_ent_t;

    m_ent_t   q[$];
    int       m_cnt16, m_cnt4;
    bit       e_pv, e_pt, e_pl, e_uv, e_ut, e_um, e_ud;
    bit [5:0] e_ptag, e_utag;

    task automatic model_reset();
        q.delete();
        m_cnt16 = 0; m_cnt4 = 0;
        e_pv = 0; e_pt = 0; e_pl = 0; e_ptag = 0;
        e_uv = 0; e_ut = 0; e_um = 0; e_ud = 0; e_utag = 0;
    endtask

    task automatic check_all();
        chk("pred_valid", pred_valid, e_pv);
        chk("pred_taken", pred_taken, e_pt);
        chk("pred_lowconf", pred_lowconf, e_pl);
        chk("pred_tag", pred_tag, e_ptag);
        chk("upd_valid", upd_valid, e_uv);
        chk("upd_train", upd_train, e_ut);
        chk("upd_mispredict", upd_mispredict, e_um);
        chk("upd_dir", upd_dir, e_ud);
        chk("upd_tag", upd_tag, e_utag);
        chk("occupancy", occupancy, q.size());
        chk("y_ready", y_ready, q.size() < DEPTH);
        chk("res_ready", res_ready, q.size() > 0);
        chk("mispredict_cnt", mispredict_cnt, m_cnt16);
        chk("small_cnt", s_cnt, m_cnt4);
        chk("small_occupancy", s_occupancy, q.size());
    endtask

    // One clock: drive inputs, advance the model by the rules, check after the edge.
    task automatic cyc(input bit yv, input int y, input bit [5:0] tg,
                       input bit rv, input bit rt, input bit fl);
        int     n;
        int     a;
        m_ent_t e;
        y_valid = yv; y_in = Y_W'(y); y_tag = tg;
        res_valid = rv; res_taken = rt; flush = fl;
        n = q.size();
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
            e_pv = 0; e_uv = 0;
        end else begin
            e_uv = rv && (n > 0);
            if (e_uv) begin
                e = q.pop_front();
                e_um = (e.taken != rt);
                e_ut = e_um || e.lowconf;
                e_ud = rt;
                e_utag = e.tag;
                if (e_um) begin
                    if (m_cnt16 < 65535) m_cnt16++;
                    if (m_cnt4 < 15) m_cnt4++;
                end
            end
            e_pv = yv && (n < DEPTH);
            if (e_pv) begin
                a = (y < 0) ? -y : y;
                e.taken = (y >= 0);
                e.lowconf = (a <= 30);
                e.tag = tg;
                q.push_back(e);
                e_pt = e.taken; e_pl = e.lowconf; e_ptag = tg;
            end
        end
        check_all();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        y_valid = 0; res_valid = 0; flush = 0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit       yv;
        int       y;
        bit [5:0] tag;
        bit       rv;
        bit       rt;
        bit       epv;
        bit       etaken;
        bit       elow;
        bit       euv;
        bit       emis;
        bit       etrain;
        bit [5:0] etag;
        int       eocc;
    } vec_t;

    vec_t vt[8];

    initial begin
        vt[0] = '{1, 100,    6'd1, 0, 0, 1, 1, 0, 0, 0, 0, 6'd1, 1};
        vt[1] = '{1, -5,     6'd2, 0, 0, 1, 0, 1, 0, 0, 0, 6'd2, 2};
        vt[2] = '{1, 30,     6'd3, 0, 0, 1, 1, 1, 0, 0, 0, 6'd3, 3};
        vt[3] = '{1, -32768, 6'd4, 0, 0, 1, 0, 0, 0, 0, 0, 6'd4, 4};
        vt[4] = '{0, 0,      6'd0, 1, 1, 0, 0, 0, 1, 0, 0, 6'd1, 3};
        vt[5] = '{0, 0,      6'd0, 1, 1, 0, 0, 0, 1, 1, 1, 6'd2, 2};
        vt[6] = '{0, 0,      6'd0, 1, 0, 0, 0, 0, 1, 1, 1, 6'd3, 1};
        vt[7] = '{0, 0,      6'd0, 1, 0, 0, 0, 0, 1, 0, 0, 6'd4, 0};

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_y_ready", y_ready, 1);
        chk("rst_res_ready", res_ready, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_pred_valid", pred_valid, 0);
        chk("rst_upd_valid", upd_valid, 0);
        chk("rst_cnt", mispredict_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        idle();

        // Table: four pushes then four resolutions
        for (int i = 0; i < 8; i++) begin
            cyc(vt[i].yv, vt[i].y, vt[i].tag, vt[i].rv, vt[i].rt, 0);
            chk($sformatf("vec%0d_pred_valid", i), pred_valid, vt[i].epv);
            chk($sformatf("vec%0d_upd_valid", i), upd_valid, vt[i].euv);
            chk($sformatf("vec%0d_occupancy", i), occupancy, vt[i].eocc);
            if (vt[i].epv) begin
                chk($sformatf("vec%0d_pred_taken", i), pred_taken, vt[i].etaken);
                chk($sformatf("vec%0d_pred_lowconf", i), pred_lowconf, vt[i].elow);
                chk($sformatf("vec%0d_pred_tag", i), pred_tag, vt[i].etag);
            end
            if (vt[i].euv) begin
                chk($sformatf("vec%0d_upd_mispredict", i), upd_mispredict, vt[i].emis);
                chk($sformatf("vec%0d_upd_train", i), upd_train, vt[i].etrain);
                chk($sformatf("vec%0d_upd_tag", i), upd_tag, vt[i].etag);
            end
        end
        chk("table_cnt", mispredict_cnt, 2);

        // Fill to DEPTH, overflow push dropped, pop+push on full, pop+push at 7
        for (int i = 0; i < DEPTH; i++) cyc(1, i * 7 - 20, 6'(10 + i), 0, 0, 0);
        chk("full_y_ready", y_ready, 0);
        chk("full_occ", occupancy, 8);
        cyc(1, 55, 6'd63, 0, 0, 0);
        chk("drop_pred_valid", pred_valid, 0);
        chk("drop_occ", occupancy, 8);
        cyc(1, 55, 6'd62, 1, 1, 0);
        chk("fullpp_upd_valid", upd_valid, 1);
        chk("fullpp_pred_valid", pred_valid, 0);
        chk("fullpp_occ", occupancy, 7);
        cyc(1, -99, 6'd40, 1, 0, 0);
        chk("pp7_pred_valid", pred_valid, 1);
        chk("pp7_upd_valid", upd_valid, 1);
        chk("pp7_occ", occupancy, 7);
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 1, 0);
        chk("drain_occ", occupancy, 0);

        // Empty: res_valid ignored even with a same-cycle push
        cyc(1, 3, 6'd21, 1, 0, 0);
        chk("empty_upd_valid", upd_valid, 0);
        chk("empty_occ", occupancy, 1);
        cyc(0, 0, 0, 1, 0, 0);
        chk("empty_then_res", upd_valid, 1);

        // Flush with 5 in flight and res_valid high
        for (int i = 0; i < 5; i++) cyc(1, -200 + i, 6'(30 + i), 0, 0, 0);
        begin
            int cnt_before;
            cnt_before = m_cnt16;
            cyc(1, 7, 6'd50, 1, 1, 1);
            chk("flush_upd_valid", upd_valid, 0);
            chk("flush_pred_valid", pred_valid, 0);
            chk("flush_occ", occupancy, 0);
            chk("flush_cnt_kept", mispredict_cnt, cnt_before);
        end
        idle();

        // Asynchronous reset mid-burst with 3 entries
        for (int i = 0; i < 3; i++) cyc(1, 500, 6'(i), 0, 0, 0);
        y_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_occ", occupancy, 0);
        chk("arst_res_ready", res_ready, 0);
        chk("arst_pred_valid", pred_valid, 0);
        chk("arst_cnt", mispredict_cnt, 0);
        do_reset();

        // 20 consecutive mispredicts saturate the 4-bit counter
        cyc(1, 100, 6'd0, 0, 0, 0);
        for (int i = 1; i <= 20; i++) cyc(1, 100, 6'(i), 1, 0, 0);
        chk("sat_cnt4", s_cnt, 15);
        chk("sat_cnt16", mispredict_cnt, 20);
        cyc(0, 0, 0, 1, 0, 0);
        chk("sat_cnt4_hold", s_cnt, 15);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            int y;
            logic signed [15:0] r16;
            int pick;
            pick = $urandom_range(0, 3);
            if (pick == 0) begin
                case ($urandom_range(0, 7))
                    0: y = -32768;
                    1: y = 32767;
                    2: y = 30;
                    3: y = -30;
                    4: y = 31;
                    5: y = -31;
                    6: y = 0;
                    default: y = -1;
                endcase
            end else begin
                r16 = 16'($urandom);
                y = r16;
            end
            cyc($urandom_range(0, 3) != 0, y, 6'($urandom), $urandom_range(0, 2) != 0,
                1'($urandom), $urandom_range(0, 31) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no completion expected completion");
        $fatal(1);
    end

endmodule
